// File: rtl/write_data_decoder.sv
// FM write-stream decoder: recovers bit cells from combined clock+data pulses, locks on the zeros preamble.
// Latency: write_pulse edge -> bit_valid 4 clocks; no backpressure, one strobe per recovered cell.
module write_data_decoder #(
  parameter int CNT_W      = 8,
  parameter int DATA_MIN   = 8,
  parameter int DATA_MAX   = 20,
  parameter int CELL_MIN   = 21,
  parameter int CELL_MAX   = 34,
  parameter int LOCK_COUNT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic write_gate,
  input  logic write_pulse,
  output logic bit_valid,
  output logic bit_data,
  output logic locked,
  output logic write_error,
  output logic error_flag
);

  localparam int SC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] D_MIN   = CNT_W'(DATA_MIN);
  localparam logic [CNT_W-1:0] D_MAX   = CNT_W'(DATA_MAX);
  localparam logic [CNT_W-1:0] C_MIN   = CNT_W'(CELL_MIN);
  localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(CELL_MAX);
  localparam logic [CNT_W-1:0] C_TMO   = CNT_W'(CELL_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0]  SC_LOCK = SC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    SYNC,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic gate_s1, gate_s;
  logic pulse_s1, pulse_s2, pulse_s3;
  logic pdet;

  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [SC_W-1:0]  sync_cnt, sync_cnt_n, sync_cnt_inc;
  logic             data_seen, data_seen_n;
  logic             bit_valid_n, bit_data_n, write_error_n, error_flag_n;

  logic in_data, in_cell, timeout;

  // Pulse path gets one extra stage so pdet is a clean registered one-cycle strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      gate_s1  <= 1'b0;
      gate_s   <= 1'b0;
      pulse_s1 <= 1'b0;
      pulse_s2 <= 1'b0;
      pulse_s3 <= 1'b0;
      pdet     <= 1'b0;
    end else begin
      gate_s1  <= write_gate;
      gate_s   <= gate_s1;
      pulse_s1 <= write_pulse;
      pulse_s2 <= pulse_s1;
      pulse_s3 <= pulse_s2;
      pdet     <= pulse_s2 & ~pulse_s3;
    end
  end

  assign in_data      = (cnt >= D_MIN) && (cnt <= D_MAX);
  assign in_cell      = (cnt >= C_MIN) && (cnt <= C_MAX);
  assign timeout      = (cnt == C_TMO);
  assign cnt_inc      = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
  assign sync_cnt_inc = sync_cnt + SC_ONE;

  always_comb begin
    state_n       = state;
    cnt_n         = cnt_inc;
    sync_cnt_n    = sync_cnt;
    data_seen_n   = data_seen;
    bit_valid_n   = 1'b0;
    bit_data_n    = 1'b0;
    write_error_n = 1'b0;
    error_flag_n  = error_flag;

    if (!gate_s) begin
      // Gate drop wins over any coincident pulse and discards the partial cell.
      state_n      = IDLE;
      cnt_n        = '0;
      sync_cnt_n   = '0;
      data_seen_n  = 1'b0;
      error_flag_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = HUNT;
          cnt_n   = '0;
        end
        HUNT: begin
          if (pdet) begin
            cnt_n      = CNT_ONE;
            sync_cnt_n = SC_ONE;
            state_n    = SYNC;
          end
        end
        SYNC: begin
          if (pdet && in_cell) begin
            cnt_n      = CNT_ONE;
            sync_cnt_n = sync_cnt_inc;
            if (sync_cnt_inc == SC_LOCK) state_n = LOCKED;
          end else if (pdet || timeout) begin
            // Off-pitch pulse restarts preamble hunting silently.
            cnt_n      = CNT_ONE;
            sync_cnt_n = SC_ONE;
          end
        end
        LOCKED: begin
          if (pdet && in_data && !data_seen) begin
            data_seen_n = 1'b1;
          end else if (pdet && in_cell) begin
            bit_valid_n = 1'b1;
            bit_data_n  = data_seen;
            data_seen_n = 1'b0;
            cnt_n       = CNT_ONE;
          end else if (pdet || timeout) begin
            write_error_n = 1'b1;
            error_flag_n  = 1'b1;
            data_seen_n   = 1'b0;
            sync_cnt_n    = '0;
            state_n       = HUNT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sync_cnt    <= '0;
      data_seen   <= 1'b0;
      bit_valid   <= 1'b0;
      bit_data    <= 1'b0;
      locked      <= 1'b0;
      write_error <= 1'b0;
      error_flag  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sync_cnt    <= sync_cnt_n;
      data_seen   <= data_seen_n;
      bit_valid   <= bit_valid_n;
      bit_data    <= bit_data_n;
      locked      <= (state_n == LOCKED);
      write_error <= write_error_n;
      error_flag  <= error_flag_n;
    end
  end

endmodule

// File: tb/tb_write_data_decoder.sv
// Directed bench for write_data_decoder: expected strobes (with their cycle) are queued by stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_write_data_decoder;

  logic clock = 1'b0;
  logic reset;
  logic write_gate;
  logic write_pulse;
  logic bit_valid, bit_data, locked, write_error, error_flag;

  write_data_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .write_gate  (write_gate),
    .write_pulse (write_pulse),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .locked      (locked),
    .write_error (write_error),
    .error_flag  (error_flag)
  );

  always #12.5 clock = ~clock;

  typedef struct {
    int cyc;
    bit is_err;
    bit data;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  last = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Pulse 'gap' cycles after the previous pulse start; 2 cycles (50 ns) wide.
  task automatic send(input int gap);
    int target;
    target = last + gap;
    while (cyc < target) tick(1);
    write_pulse = 1'b1;
    last = cyc;
    tick(2);
    write_pulse = 1'b0;
  endtask

  task automatic exp_bit(input bit d);
    ev_t e;
    e.cyc = last + 4; e.is_err = 1'b0; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input int at_cyc);
    ev_t e;
    e.cyc = at_cyc; e.is_err = 1'b1; e.data = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bit_valid"}, bit_valid, 0);
    check({tag, "_bit_data"}, bit_data, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_write_error"}, write_error, 0);
    check({tag, "_error_flag"}, error_flag, 0);
  endtask

  task automatic preamble();
    send(0); send(28); send(28); send(28);
  endtask

  // Monitor: every output strobe must match the head of the expectation queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (bit_valid && write_error) begin
        n_cmp++; n_fail++;
        $display("FAIL strobe_overlap: bit_valid=1 write_error=1, required not both (cycle %0d)", cyc);
      end else if (bit_valid || write_error) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_strobe: bit_valid=%0d write_error=%0d, required none (cycle %0d)",
                   bit_valid, write_error, cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_is_error", write_error, e.is_err);
          if (!e.is_err) check("bit_data", bit_data, e.data);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; write_gate = 1'b0; write_pulse = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    tick(2);
    write_gate = 1'b1;
    tick(4);

    // Preamble lock: locked rises 4 clocks after the 4th pulse, not before.
    preamble();
    tick(1);
    check("lock_early", locked, 0);
    tick(1);
    check("lock_after_preamble", locked, 1);

    // Data cells including window boundaries.
    send(14); send(14); exp_bit(1'b1);
    send(28); exp_bit(1'b0);
    send(8);  send(26); exp_bit(1'b1);
    send(21); exp_bit(1'b0);
    send(20); send(14); exp_bit(1'b1);
    check("flag_clean", error_flag, 0);

    // Pulse at cnt=5 breaks lock.
    send(5); exp_err(last + 4);
    tick(3);
    check("err5_locked", locked, 0);
    check("err5_flag", error_flag, 1);

    // Relock; sticky flag survives.
    send(28); send(28); send(28); send(28);
    tick(2);
    check("relock1_locked", locked, 1);
    check("relock1_flag", error_flag, 1);
    send(14); send(14); exp_bit(1'b1);

    // Missing clock: error when cnt hits 35 (pdet at last+3, error registered 36 later).
    exp_err(last + 39);
    tick(45);
    check("timeout_locked", locked, 0);

    send(0); send(28); send(28); send(28);
    tick(2);
    check("relock2_locked", locked, 1);

    // Second data pulse in one cell.
    send(14); send(4); exp_err(last + 4);
    tick(4);
    check("dbl_data_locked", locked, 0);

    send(28); send(28); send(28); send(28);
    tick(2);
    check("relock3_locked", locked, 1);

    // Gate drop coincident with the cell clock pulse: no bit, no error, flag cleared.
    send(14);
    while (cyc < last + 14) tick(1);
    write_pulse = 1'b1;
    tick(1);
    write_gate = 1'b0;
    tick(1);
    write_pulse = 1'b0;
    tick(6);
    check("gate_low_flag", error_flag, 0);
    check("gate_low_locked", locked, 0);

    // Reset while locked with a data pulse pending.
    write_gate = 1'b1;
    tick(4);
    preamble();
    tick(2);
    check("relock4_locked", locked, 1);
    send(14);
    tick(4);
    reset = 1'b1;
    tick(1);
    check_idle_outputs("mid_reset");
    tick(1);
    reset = 1'b0;
    tick(4);
    send(14); send(28); send(28);
    tick(4);
    check("post_reset_3_pulses", locked, 0);
    send(28);
    tick(2);
    check("post_reset_relock", locked, 1);
    send(28); exp_bit(1'b0);

    tick(10);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
